// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer: rolls N dice through an external roller and sums the results; DICE_RANGE_CHECK_EN enables out-of-range rejection
module dice_roll_sequencer #(
  parameter int ROLL_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  die_count,
  input  logic [1:0]  die_type,
  output logic [1:0]  die_select,
  output logic        roll,
  input  logic [7:0]  rolled_number,
  output logic        busy,
  output logic        done,
  output logic [11:0] total,
  output logic        error
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ACCUM = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [3:0] LAT_M1 = 4'(ROLL_LATENCY - 1);
  logic [2:0]  state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  sel_q, sel_d;
  logic [11:0] total_q, total_d;
  logic        err_q, err_d;
  logic        in_range;
`ifdef DICE_RANGE_CHECK_EN
  logic [7:0] sides;
  // face count of the latched die type bounds the legal roll values
  always_comb sides = sel_q == 2'd0 ? 8'd4 : sel_q == 2'd1 ? 8'd6 : sel_q == 2'd2 ? 8'd8 : 8'd20;
  assign in_range = (rolled_number != 8'd0) && (rolled_number <= sides);
`else
  assign in_range = 1'b1;
`endif
  // sequencing: issue a roll, wait out the roller latency, accumulate, repeat per die
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    sel_d   = sel_q;
    total_d = total_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        total_d = 12'd0;
        err_d   = 1'b0;
        if (die_count != 4'd0) begin
          rem_d   = die_count;
          sel_d   = die_type;
          state_d = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      ISSUE: begin
        wait_d  = LAT_M1;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = wait_q == 4'd0 ? ACCUM : WAIT;
        wait_d  = wait_q == 4'd0 ? wait_q : wait_q - 4'd1;
      end
      ACCUM: begin
        total_d = in_range ? total_q + {4'd0, rolled_number} : total_q;
        err_d   = err_q | ~in_range;
        rem_d   = rem_q - 4'd1;
        state_d = rem_q == 4'd1 ? DONE : ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
      wait_q  <= 4'd0;
      sel_q   <= 2'd0;
      total_q <= 12'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      sel_q   <= sel_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end
  assign roll       = state_q == ISSUE;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign total      = total_q;
  assign die_select = sel_q;
  assign error      = err_q;
endmodule

// File: tb/tb_dice_roll_sequencer.sv
// tb_dice_roll_sequencer: directed and randomized dice sequences checked against a cycle-schedule model
module tb_dice_roll_sequencer;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  die_count = 4'd0;
  logic [1:0]  die_type = 2'd0;
  logic        start [2];
  logic [7:0]  rn [2];
  logic        roll [2];
  logic        busy [2];
  logic        done [2];
  logic        err [2];
  logic [1:0]  dsel [2];
  logic [11:0] tot [2];
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  dice_roll_sequencer #(.ROLL_LATENCY(LAT0)) u0 (
    .clock(clock), .reset(reset), .start(start[0]), .die_count(die_count), .die_type(die_type),
    .die_select(dsel[0]), .roll(roll[0]), .rolled_number(rn[0]), .busy(busy[0]), .done(done[0]),
    .total(tot[0]), .error(err[0]));
  dice_roll_sequencer #(.ROLL_LATENCY(LAT1)) u1 (
    .clock(clock), .reset(reset), .start(start[1]), .die_count(die_count), .die_type(die_type),
    .die_select(dsel[1]), .roll(roll[1]), .rolled_number(rn[1]), .busy(busy[1]), .done(done[1]),
    .total(tot[1]), .error(err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit ok_val(input logic [7:0] v, input logic [1:0] t);
`ifdef DICE_RANGE_CHECK_EN
    int sides;
    sides = t == 2'd0 ? 4 : t == 2'd1 ? 6 : t == 2'd2 ? 8 : 20;
    return v >= 1 && v <= sides;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_roll"}, roll[i], 0);
    chk({tag, "_busy"}, busy[i], 0);
    chk({tag, "_done"}, done[i], 0);
    chk({tag, "_total"}, tot[i], 0);
    chk({tag, "_error"}, err[i], 0);
    chk({tag, "_sel"}, dsel[i], 0);
  endtask

  // one sequence on instance i; sample k is taken 1ns after the k-th edge following the accepting edge
  task automatic run(input int i, input int n, input logic [1:0] t, input logic [7:0] vals[$],
                     input bit hold, input int abort_k);
    int lat;
    int p;
    int last;
    int acc;
    bit e;
    lat  = i == 0 ? LAT0 : LAT1;
    p    = lat + 2;
    last = n * p;
    acc  = 0;
    e    = 0;
    die_count = 4'(n);
    die_type  = t;
    start[i]  = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k <= last + 1; k++) begin
      if (n > 0 && k > 0 && k % p == 0 && k <= last) begin
        if (ok_val(vals[k/p-1], t)) acc += int'(vals[k/p-1]);
        else e = 1;
      end
      if (k == abort_k) begin
        reset = 1'b1;
        start[i] = 1'b0;
        @(posedge clock); #1;
        chk_idle(i, "abort");
        reset = 1'b0;
        repeat (3) begin
          @(posedge clock); #1;
          chk("abort_nodone", done[i], 0);
          chk("abort_noroll", roll[i], 0);
        end
        return;
      end
      chk("roll", roll[i], n > 0 && k < last && k % p == 0);
      chk("busy", busy[i], k <= last);
      chk("done", done[i], k == last);
      chk("total", tot[i], acc);
      chk("error", err[i], e);
      if (n > 0 && k <= last) chk("die_select", dsel[i], t);
      if (n > 0 && k < last && k % p == 0) rn[i] = 8'($urandom);
      if (n > 0 && k < last && k % p == lat) rn[i] = vals[k/p];
      if (k <= last) begin
        start[i]  = hold ? 1'b1 : 1'($urandom_range(0, 1));
        die_count = 4'($urandom);
        die_type  = 2'($urandom);
        @(posedge clock); #1;
      end else begin
        start[i] = hold;
      end
    end
  endtask

  initial begin
    logic [7:0] q[$];
    start[0] = 1'b0;
    start[1] = 1'b0;
    rn[0] = 8'd0;
    rn[1] = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    reset = 1'b0;
    @(posedge clock); #1;
    q = '{8'd2, 8'd5, 8'd6};
    run(0, 3, 2'b01, q, 1'b0, -1);
    chk("basic_total13", tot[0], 13);
    q = {};
    run(0, 0, 2'b10, q, 1'b0, -1);
    q = '{8'd7, 8'd3};
    run(0, 2, 2'b00, q, 1'b0, -1);
    q = '{8'd4, 8'd1};
    run(0, 2, 2'b00, q, 1'b0, -1);
    q = {};
    for (int j = 0; j < 15; j++) q.push_back(8'd20);
    run(1, 15, 2'b11, q, 1'b0, -1);
    chk("long_total300", tot[1], 300);
    q = '{8'd9};
    run(0, 1, 2'b11, q, 1'b1, -1);
    run(0, 1, 2'b11, q, 1'b1, -1);
    run(0, 1, 2'b11, q, 1'b0, -1);
    chk("held_total9", tot[0], 9);
    q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run(0, 4, 2'b10, q, 1'b0, LAT0 + 3);
    for (int r = 0; r < 10; r++) begin
      int inst;
      int n;
      inst = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 15));
      q = {};
      for (int j = 0; j < n; j++)
        q.push_back($urandom_range(0, 1) != 0 ? 8'($urandom_range(0, 25)) : 8'($urandom_range(0, 255)));
      run(inst, n, 2'($urandom), q, 1'b0, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dice_roll_sequencer.md
DICE_ROLL_SEQUENCER -- requirements
Module: dice_roll_sequencer

Interface
REQ-001 Parameter ROLL_LATENCY, default 1, is the clock edges from the roll pulse to a valid rolled_number at the dice roller (legal 1..15).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multi-die roll; sampled only in IDLE.
REQ-005 die_count  input  4  number of dice to roll (0..15); latched on accepted start.
REQ-006 die_type  input  2  00=d4, 01=d6, 10=d8, 11=d20; latched on accepted start.
REQ-007 die_select  output  2  die type driven to the dice roller; holds the latched die_type while busy.
REQ-008 roll  output  1  one-cycle roll request to the dice roller.
REQ-009 rolled_number  input  8  result returned by the dice roller.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when the sequence completes.
REQ-012 total  output  12  sum of accepted rolls; valid from the done pulse until the next accepted start.
REQ-013 error  output  1  sticky out-of-range flag (see Configuration); cleared on accepted start.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT, ACCUM and DONE.
REQ-015 IDLE: start=1 with die_count!=0 SHALL latch die_count and die_type, clear total and error, and go to ISSUE.
REQ-016 IDLE: start=1 with die_count=0 SHALL clear total and error and go directly to DONE; roll is never asserted.
REQ-017 ISSUE: roll SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT; roll SHALL be 0 in all other states.
REQ-018 WAIT: the FSM SHALL remain in WAIT for exactly ROLL_LATENCY cycles, then go to ACCUM.
REQ-019 ACCUM: the FSM SHALL sample rolled_number, add the accepted value zero-extended to 12 bits into total, and decrement the remaining count.
REQ-020 ACCUM: when the remaining count reaches 0 the FSM SHALL go to DONE; otherwise it SHALL go to ISSUE.
REQ-021 DONE: done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-022 Latency: done SHALL assert N*(ROLL_LATENCY+2)+1 cycles after the edge that accepts start, where N is die_count (N=0 gives 1 cycle).
REQ-023 start SHALL be ignored while busy=1, and a start asserted during DONE SHALL be ignored.
REQ-024 A start held high SHALL be accepted again on the first IDLE cycle after DONE.
REQ-025 total SHALL never wrap, since the worst case is 15*255=3825 < 4096.
REQ-026 Inputs die_count and die_type SHALL be ignored while busy; changing them mid-sequence SHALL not affect die_select or the roll count.

Reset
REQ-027 reset=1 SHALL force IDLE on the next edge, from any state including mid-sequence.
REQ-028 Reset values SHALL be: roll=0, done=0, busy=0, error=0, total=0, die_select=00, remaining count=0.
REQ-029 reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 The macro DICE_RANGE_CHECK_EN SHALL compile range checking in or out of the block.
REQ-031 With DICE_RANGE_CHECK_EN defined, a value outside 1..sides (sides 4/6/8/20 per the latched die_type) SHALL NOT be added to total, SHALL set error, and SHALL still consume one die.
REQ-032 Without DICE_RANGE_CHECK_EN, error SHALL be tied to 0 and every sampled value SHALL be added to total.

Verification
REQ-033 ROLL_LATENCY=1; start with die_count=3, die_type=01; responder returns 2,5,6 -> three roll pulses 3 cycles apart, die_select=01 throughout, done at cycle 10, total=13, error=0.
REQ-034 start with die_count=0 -> no roll pulse, done one cycle later, total=0, busy high for exactly 1 cycle.
REQ-035 With DICE_RANGE_CHECK_EN, die_count=2, die_type=00; responder returns 7 then 3 -> total=3, error=1; a new start clears error.
REQ-036 die_count=4; reset asserted during the second WAIT -> next cycle in IDLE, roll=0, busy=0, total=0, and no done pulse.
REQ-037 start held high continuously with die_count=1 and responder value 9 on a d20 -> back-to-back sequences, each with done then one IDLE cycle, total=9 each time; start pulses while busy produce no extra rolls.
REQ-038 ROLL_LATENCY=3; die_count=15, die_type=11, responder always 20 -> done at cycle 76, total=300.
